cache_16_refill: RTL and testbench

//  Line-fill controller on the memory side of the 16-word, two-half cache. A miss request starts the fill.
//  The block fetches the 4-word block from word-addressed memory, one word per read handshake.
//  It assembles the block into the cache's 8-word fill bus, then drives the cache's tag input and a one-hot load strobe.
//  Per-index round-robin victim selection chooses which half (way) is overwritten.

---
 rtl/cache_16_refill.sv | 145 ++++++++++++++
 tb/tb_cache_16_refill.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_16_refill.sv
`default_nettype none
// ============================================================================
// Module      : cache_16_refill
// Description : Line-fill controller for the 16-word two-way cache. Fetches a
//               4-word block, places it on the 8-word fill bus, and pulses a
//               one-hot load strobe chosen by per-index round-robin victims.
//               Optional macro CACHE_REFILL_CRIT_FIRST_EN: critical-word-first
//               fetch order plus a critical-word output.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_16_refill #(
   parameter int WIDTH     = 32,
   parameter int BLK_WORDS = 4,
   parameter int ADDR_W    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 miss_req,
   input  logic [1:0]           miss_tag,
   input  logic                 miss_index,
   input  logic [1:0]           miss_offset,
   output logic                 busy,
   output logic                 mem_rd,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic                 mem_ready,
   input  logic [WIDTH-1:0]     mem_rdata,
   output logic [1:0]           out_tag,
   output logic [WIDTH*8-1:0]   out_cache_bus,
   output logic [3:0]           is_load_bus,
   output logic                 fill_done,
   output logic                 crit_valid,
   output logic [WIDTH-1:0]     crit_data
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_REQ  = 2'd1;
   localparam logic [1:0] c_LOAD = 2'd2;

   localparam logic [1:0] c_CNT_LAST = 2'(BLK_WORDS - 1);

`ifdef CACHE_REFILL_CRIT_FIRST_EN
   localparam logic c_CRIT_FIRST = 1'b1;
`else
   localparam logic c_CRIT_FIRST = 1'b0;
`endif

   logic [1:0]          r_state;
   logic [1:0]          r_tag;
   logic                r_index;
   logic [1:0]          r_off_start;
   logic [1:0]          r_cnt;
   logic [1:0]          r_victim;
   logic [WIDTH*8-1:0]  r_bus;

   logic [1:0]          w_cur_off;
   logic [2:0]          w_slot;
   logic [1:0]          w_lsel;
   logic                w_hs;

   // Offset wraps naturally in 2 bits, giving the critical-word-first order.
   assign w_cur_off = r_off_start + r_cnt;
   // Bus word number is 7 - (4*index + offset), i.e. the bitwise inverse.
   assign w_slot    = ~{r_index, w_cur_off};
   assign w_lsel    = {r_victim[r_index], r_index};
   assign w_hs      = (r_state == c_REQ) && mem_ready;

   assign busy          = (r_state != c_IDLE);
   assign mem_rd        = (r_state == c_REQ);
   assign mem_addr      = ADDR_W'({r_tag, r_index, w_cur_off});
   assign out_tag       = r_tag;
   assign out_cache_bus = r_bus;
   assign fill_done     = (r_state == c_LOAD);
   assign is_load_bus   = (r_state == c_LOAD) ? (4'b1000 >> w_lsel) : 4'b0000;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= c_IDLE;
         r_tag       <= 2'b00;
         r_index     <= 1'b0;
         r_off_start <= 2'b00;
         r_cnt       <= 2'b00;
         r_victim    <= 2'b00;
         r_bus       <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (miss_req) begin
                  r_state     <= c_REQ;
                  r_tag       <= miss_tag;
                  r_index     <= miss_index;
                  r_off_start <= c_CRIT_FIRST ? miss_offset : 2'b00;
                  r_cnt       <= 2'b00;
               end
            end
            c_REQ: begin
               if (mem_ready) begin
                  for (int j = 0; j < 8; j++) begin
                     if (w_slot == 3'(j)) begin
                        r_bus[j*WIDTH +: WIDTH] <= mem_rdata;
                     end
                  end
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == c_CNT_LAST) begin
                     r_state <= c_LOAD;
                  end
               end
            end
            c_LOAD: begin
               r_victim[r_index] <= ~r_victim[r_index];
               r_state           <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

`ifdef CACHE_REFILL_CRIT_FIRST_EN
   logic             r_crit_valid;
   logic [WIDTH-1:0] r_crit_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_crit_valid <= 1'b0;
         r_crit_data  <= '0;
      end else begin
         r_crit_valid <= w_hs && (r_cnt == 2'b00);
         if (w_hs && (r_cnt == 2'b00)) begin
            r_crit_data <= mem_rdata;
         end
      end
   end

   assign crit_valid = r_crit_valid;
   assign crit_data  = r_crit_data;
`else
   logic w_unused_hs;
   assign w_unused_hs = w_hs;
   assign crit_valid  = 1'b0;
   assign crit_data   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_16_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_16_refill
// Description : Scoreboard bench for cache_16_refill; stimulus pushes expected
//               reads/loads/critical words, a negedge monitor pops and checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_16_refill;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          miss_req = 1'b0;
   logic [1:0]    miss_tag = 2'b00;
   logic          miss_index = 1'b0;
   logic [1:0]    miss_offset = 2'b00;
   logic          busy;
   logic          mem_rd;
   logic [4:0]    mem_addr;
   logic          mem_ready = 1'b1;
   logic [31:0]   mem_rdata;
   logic [1:0]    out_tag;
   logic [255:0]  out_cache_bus;
   logic [3:0]    is_load_bus;
   logic          fill_done;
   logic          crit_valid;
   logic [31:0]   crit_data;

   cache_16_refill #(.WIDTH(32), .BLK_WORDS(4), .ADDR_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .miss_req      (miss_req),
      .miss_tag      (miss_tag),
      .miss_index    (miss_index),
      .miss_offset   (miss_offset),
      .busy          (busy),
      .mem_rd        (mem_rd),
      .mem_addr      (mem_addr),
      .mem_ready     (mem_ready),
      .mem_rdata     (mem_rdata),
      .out_tag       (out_tag),
      .out_cache_bus (out_cache_bus),
      .is_load_bus   (is_load_bus),
      .fill_done     (fill_done),
      .crit_valid    (crit_valid),
      .crit_data     (crit_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk_word(input logic [4:0] a);
      return {24'hC0FFEE, 3'b000, a};
   endfunction

   // Memory model: data is a fixed function of the word address.
   assign mem_rdata = mk_word(mem_addr);

   typedef struct {
      int unsigned   due;
      logic [3:0]    lb;
      logic [1:0]    tag;
      logic          idx;
      logic [127:0]  half;
   } load_t;

   typedef struct {
      int unsigned   due;
      logic [31:0]   data;
   } crit_t;

   logic [4:0]    addr_q[$];
   load_t         load_q[$];
   crit_t         crit_q[$];
   load_t         m_e;
   crit_t         m_c;
   int unsigned   cyc = 0;
   int            total = 0;
   int            bad = 0;
   int            hs = 0;
   int            stall_left = 0;
   int            stall_word = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory handshake driver: optional stall window on a chosen word.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0 && mem_rd && hs == stall_word) begin
            mem_ready = 1'b0;
            stall_left--;
         end else begin
            mem_ready = 1'b1;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         hs = 0;
      end else begin
         if (mem_rd) begin
            if (mem_ready) begin
               if (addr_q.size() == 0) chk("unexpected_rd", {251'd0, mem_addr}, 256'd0);
               else chk("mem_addr", {251'd0, mem_addr}, {251'd0, addr_q.pop_front()});
               hs++;
            end else if (addr_q.size() > 0) begin
               chk("stall_addr", {251'd0, mem_addr}, {251'd0, addr_q[0]});
            end
         end
         if (fill_done) begin
            hs = 0;
            if (load_q.size() == 0) begin
               chk("unexpected_load", {252'd0, is_load_bus}, 256'd0);
            end else begin
               m_e = load_q.pop_front();
               chk("load_bus", {252'd0, is_load_bus}, {252'd0, m_e.lb});
               chk("out_tag", {254'd0, out_tag}, {254'd0, m_e.tag});
               chk("fill_time", {224'd0, cyc}, {224'd0, m_e.due});
               chk("bus_half", m_e.idx ? {128'd0, out_cache_bus[127:0]}
                                       : {128'd0, out_cache_bus[255:128]},
                   {128'd0, m_e.half});
               chk("busy_at_load", {255'd0, busy}, 256'd1);
            end
         end else if (is_load_bus != 4'b0000) begin
            chk("stray_load", {252'd0, is_load_bus}, 256'd0);
         end
         if (crit_valid) begin
            if (crit_q.size() == 0) begin
               chk("unexpected_crit", {255'd0, crit_valid}, 256'd0);
            end else begin
               m_c = crit_q.pop_front();
               chk("crit_time", {224'd0, cyc}, {224'd0, m_c.due});
               chk("crit_data", {224'd0, crit_data}, {224'd0, m_c.data});
            end
         end
      end
   end

   // Issues one miss; expectations are pushed before the request goes out.
   task automatic fill(input logic [1:0] tag, input logic idx, input logic [1:0] off,
                       input logic [3:0] lb, input int sw, input int sn,
                       input int nwords, input bit expect_load);
      load_t   e;
      crit_t   c;
      logic [1:0] o;
      @(negedge clk);
      for (int k = 0; k < nwords; k++) begin
`ifdef CACHE_REFILL_CRIT_FIRST_EN
         o = off + 2'(k);
`else
         o = 2'(k);
`endif
         addr_q.push_back({tag, idx, o});
      end
      if (expect_load) begin
         e.due = cyc + 5 + sn;
         e.lb  = lb;
         e.tag = tag;
         e.idx = idx;
         for (int k = 0; k < 4; k++) e.half[127-32*k -: 32] = mk_word({tag, idx, 2'(k)});
         load_q.push_back(e);
      end
`ifdef CACHE_REFILL_CRIT_FIRST_EN
      c.due  = cyc + 2;
      c.data = mk_word({tag, idx, off});
      crit_q.push_back(c);
`else
      c.due  = 0;
      c.data = 32'd0;
`endif
      stall_word  = sw;
      stall_left  = sn;
      miss_tag    = tag;
      miss_index  = idx;
      miss_offset = off;
      miss_req    = 1'b1;
      @(negedge clk);
      miss_req    = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((load_q.size() != 0 || addr_q.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("timeout", 256'd1, 256'd0);
         load_q.delete();
         addr_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {255'd0, busy}, 256'd0);
      chk("rst_mem_rd", {255'd0, mem_rd}, 256'd0);
      chk("rst_mem_addr", {251'd0, mem_addr}, 256'd0);
      chk("rst_out_tag", {254'd0, out_tag}, 256'd0);
      chk("rst_bus", out_cache_bus, 256'd0);
      chk("rst_load_bus", {252'd0, is_load_bus}, 256'd0);
      chk("rst_fill_done", {255'd0, fill_done}, 256'd0);
      chk("rst_crit_valid", {255'd0, crit_valid}, 256'd0);
      rst = 1'b1;

      // Basic fill, then round-robin on index 1.
      fill(2'b10, 1'b0, 2'd0, 4'b1000, 0, 0, 4, 1'b1); wait_done();
      fill(2'b01, 1'b1, 2'd0, 4'b0100, 0, 0, 4, 1'b1); wait_done();
      fill(2'b01, 1'b1, 2'd0, 4'b0001, 0, 0, 4, 1'b1); wait_done();
      fill(2'b01, 1'b1, 2'd0, 4'b0100, 0, 0, 4, 1'b1); wait_done();

      // Stall three cycles on word 1; index 0 now uses way 1.
      fill(2'b11, 1'b0, 2'd0, 4'b0010, 1, 3, 4, 1'b1); wait_done();

      // Extra miss_req pulses at cycles 2 and 5 must be dropped.
      fill(2'b00, 1'b0, 2'd0, 4'b1000, 0, 0, 4, 1'b1);
      miss_tag = 2'b11; miss_index = 1'b1; miss_req = 1'b1;
      @(negedge clk); miss_req = 1'b0;
      @(negedge clk);
      @(negedge clk); miss_req = 1'b1;
      @(negedge clk); miss_req = 1'b0;
      wait_done();
      repeat (6) @(negedge clk);
      chk("drop_busy", {255'd0, busy}, 256'd0);

      // Reset after two words: no load, victims cleared.
      fill(2'b10, 1'b0, 2'd0, 4'b0000, 0, 0, 2, 1'b0);
      n = 0;
      while (hs != 2 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (n >= 50) chk("rst_wait_timeout", 256'd1, 256'd0);
      #1 rst = 1'b0;
      #1;
      chk("abort_busy", {255'd0, busy}, 256'd0);
      chk("abort_load_bus", {252'd0, is_load_bus}, 256'd0);
      chk("abort_mem_rd", {255'd0, mem_rd}, 256'd0);
      chk("abort_bus", out_cache_bus, 256'd0);
      addr_q.delete();
      crit_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;

      fill(2'b10, 1'b0, 2'd0, 4'b1000, 0, 0, 4, 1'b1); wait_done();
      fill(2'b10, 1'b1, 2'd3, 4'b0100, 0, 0, 4, 1'b1); wait_done();

      chk("addr_q_empty", {224'd0, addr_q.size()}, 256'd0);
      chk("load_q_empty", {224'd0, load_q.size()}, 256'd0);
      chk("crit_q_empty", {224'd0, crit_q.size()}, 256'd0);
`ifndef CACHE_REFILL_CRIT_FIRST_EN
      chk("crit_data_tied", {224'd0, crit_data}, 256'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
